// File: rtl/addr_hash_pipe.sv
// Two-stage multiplicative address hash with LFSR-refreshed coefficients.
// A refresh drains the pipe first, so every result uses the pair active at its accept edge.
module addr_hash_pipe #(
    parameter int          ADDR_WIDTH  = 64,
    parameter int          BUCKET_BITS = 10,
    parameter logic [31:0] SEED_A      = 32'h9E3779B1,
    parameter logic [31:0] SEED_B      = 32'h85EBCA77
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_WIDTH-1:0]  in_addr,
    input  logic                   refresh_req,
    output logic                   refresh_busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BUCKET_BITS-1:0] out_bucket,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic [31:0]            coe_a,
    output logic [31:0]            coe_b,
    output logic [7:0]             epoch
);

    localparam int EXT_W = (ADDR_WIDTH > 64) ? ADDR_WIDTH : 64;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        RELOAD = 2'd2
    } state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        lfsr_step = (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h00000000);
    endfunction

    state_t                 state;
    logic                   s1_valid;
    logic [ADDR_WIDTH-1:0]  s1_addr;
    logic [31:0]            s1_prod_a;
    logic [31:0]            s1_prod_b;

    logic [EXT_W-1:0]       addr_ext;
    logic [31:0]            upper;
    logic [31:0]            lower;
    logic [31:0]            prod_a;
    logic [31:0]            prod_b;
    logic [31:0]            sum;
    logic                   s2_adv;
    logic                   s1_adv;
    logic                   in_fire;

    assign addr_ext = EXT_W'(in_addr);
    assign upper    = addr_ext[63:32];
    assign lower    = addr_ext[31:0];
    assign prod_a   = coe_a * upper;
    assign prod_b   = coe_b * lower;
    assign sum      = s1_prod_a + s1_prod_b;

    // S2 frees up when empty or consumed; S1 frees up when empty or moving into S2.
    assign s2_adv       = !out_valid || out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign in_ready     = !rst && (state == RUN) && s1_adv;
    assign in_fire      = in_valid && in_ready;
    assign refresh_busy = (state != RUN);

    // Stage 1: capture address and both truncated products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_prod_a <= 32'h0;
            s1_prod_b <= 32'h0;
        end else if (s1_adv) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_addr   <= in_addr;
                s1_prod_a <= prod_a;
                s1_prod_b <= prod_b;
            end
        end
    end

    // Stage 2: bucket = top BUCKET_BITS of the 32-bit sum; holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_bucket <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_addr   <= s1_addr;
                out_bucket <= sum[31 -: BUCKET_BITS];
            end
        end
    end

    // Refresh controller: drain in-flight work, then step coefficients for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            coe_a <= SEED_A;
            coe_b <= SEED_B;
            epoch <= 8'd0;
        end else begin
            case (state)
                RUN: begin
                    if (refresh_req) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!s1_valid && !out_valid) begin
                        state <= RELOAD;
                    end
                end
                RELOAD: begin
                    coe_a <= lfsr_step(coe_a);
                    coe_b <= lfsr_step(coe_b) | 32'h00000001;
                    epoch <= epoch + 8'd1;
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addr_hash_pipe.sv
// Scoreboard bench for addr_hash_pipe: expectations queued at accept, compared at output.
module tb_addr_hash_pipe;

    localparam int          AW = 64;
    localparam int          BB = 10;
    localparam logic [31:0] SA = 32'h9E3779B1;
    localparam logic [31:0] SB = 32'h85EBCA77;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic          refresh_req;
    logic          refresh_busy;
    logic          out_valid;
    logic          out_ready;
    logic [BB-1:0] out_bucket;
    logic [AW-1:0] out_addr;
    logic [31:0]   coe_a;
    logic [31:0]   coe_b;
    logic [7:0]    epoch;

    always #5 clk = ~clk;

    addr_hash_pipe #(.ADDR_WIDTH(AW), .BUCKET_BITS(BB), .SEED_A(SA), .SEED_B(SB)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .refresh_req(refresh_req), .refresh_busy(refresh_busy),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bucket(out_bucket), .out_addr(out_addr),
        .coe_a(coe_a), .coe_b(coe_b), .epoch(epoch)
    );

    typedef struct {
        logic [63:0] addr;
        logic [9:0]  bucket;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_count = 0;
    int          out_count = 0;
    bit          lat_check = 1'b0;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [7:0]  m_epoch;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] model_hash(input logic [63:0] addr, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] pa;
        logic [63:0] pb;
        logic [31:0] s;
        pa = {32'h0, a} * {32'h0, addr[63:32]};
        pb = {32'h0, b} * {32'h0, addr[31:0]};
        s  = pa[31:0] + pb[31:0];
        return s[31 -: BB];
    endfunction

    function automatic logic [31:0] model_step(input logic [31:0] x);
        if (x[0]) return (x >> 1) ^ 32'h80200003;
        else      return x >> 1;
    endfunction

    // Monitor: compare head of scoreboard while output valid, pop on consume, push on accept.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check_val("spurious_out", {63'h0, out_valid}, 64'h0);
                end else begin
                    check_val("out_bucket", {54'h0, out_bucket}, {54'h0, sb[0].bucket});
                    check_val("out_addr", out_addr, sb[0].addr);
                    if (out_ready) begin
                        if (lat_check) check_val("latency", 64'(cyc - sb[0].cyc), 64'd2);
                        void'(sb.pop_front());
                        out_count++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back('{addr: in_addr, bucket: model_hash(in_addr, m_a, m_b), cyc: cyc});
                acc_count++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] addr);
        int n;
        bit acc;
        n        = 0;
        in_valid = 1'b1;
        in_addr  = addr;
        forever begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) break;
            n++;
            if (n > 100) begin
                check_val("send_timeout", 64'(n), 64'd0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check_val("drain_done", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (refresh_busy && n < 50) begin
            tick();
            n++;
        end
        check_val("busy_clear", {63'h0, refresh_busy}, 64'h0);
    endtask

    task automatic model_reload();
        m_a     = model_step(m_a);
        m_b     = model_step(m_b) | 32'h1;
        m_epoch = m_epoch + 8'd1;
    endtask

    task automatic send_vectors();
        send(64'h0000_0001_0000_0000);
        send(64'h0000_0000_0000_0001);
        send(64'h0000_0001_0000_0001);
        send(64'h0000_0000_0000_0000);
    endtask

    int base;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; refresh_req = 1'b0; out_ready = 1'b0;
        m_a = SA; m_b = SB; m_epoch = 8'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check_val("rst_in_ready", {63'h0, in_ready}, 64'h0);
        check_val("rst_busy", {63'h0, refresh_busy}, 64'h0);
        check_val("rst_coe_a", {32'h0, coe_a}, {32'h0, SA});
        check_val("rst_coe_b", {32'h0, coe_b}, {32'h0, SB});
        check_val("rst_epoch", {56'h0, epoch}, 64'h0);
        check_val("rst_out_bucket", {54'h0, out_bucket}, 64'h0);
        check_val("rst_out_addr", out_addr, 64'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_val("in_ready_after_rst", {63'h0, in_ready}, 64'h1);

        // Known vectors, back-to-back, 2-cycle latency.
        out_ready = 1'b1; lat_check = 1'b1;
        tick();
        send_vectors();
        wait_drain();
        lat_check = 1'b0;

        // Backpressure: exactly two accepts, then release and stream.
        out_ready = 1'b0;
        base = acc_count;
        fork
            begin
                for (int i = 0; i < 10; i++) send({$urandom(), $urandom()});
            end
            begin
                repeat (6) @(negedge clk);
                #2;
                check_val("stall_accepts", 64'(acc_count - base), 64'd2);
                check_val("stall_in_ready", {63'h0, in_ready}, 64'h0);
                check_val("stall_out_valid", {63'h0, out_valid}, 64'h1);
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        wait_drain();
        check_val("none_lost", 64'(out_count), 64'(acc_count));

        // Refresh with two results in flight; second accept coincides with the request.
        send(64'h1234_5678_9ABC_DEF0);
        refresh_req = 1'b1;
        base = acc_count;
        send(64'h0FED_CBA9_8765_4321);
        refresh_req = 1'b0;
        check_val("refresh_cycle_accept", 64'(acc_count - base), 64'd1);
        check_val("drain_busy", {63'h0, refresh_busy}, 64'h1);
        check_val("drain_in_ready", {63'h0, in_ready}, 64'h0);
        wait_idle();
        check_val("drained_before_reload", 64'(sb.size()), 64'd0);
        model_reload();
        check_val("coe_a_first", {32'h0, coe_a}, 64'h0000_0000_CF3B_BCDB);
        check_val("coe_b_first", {32'h0, coe_b}, 64'h0000_0000_C2D5_E539);
        check_val("coe_a_model", {32'h0, coe_a}, {32'h0, m_a});
        check_val("epoch_one", {56'h0, epoch}, 64'd1);
        for (int i = 0; i < 3; i++) send({$urandom(), $urandom()});
        wait_drain();

        // Extra pulses during DRAIN/RELOAD ignored; 256 refreshes wrap epoch.
        for (int i = 2; i <= 256; i++) begin
            refresh_req = 1'b1;
            tick(); tick(); tick();
            refresh_req = 1'b0;
            wait_idle();
            model_reload();
            check_val("loop_epoch", {56'h0, epoch}, {56'h0, m_epoch});
            check_val("loop_coe_a", {32'h0, coe_a}, {32'h0, m_a});
            check_val("loop_coe_b", {32'h0, coe_b}, {32'h0, m_b});
            check_val("loop_coe_b_odd", {63'h0, coe_b[0]}, 64'h1);
        end
        check_val("epoch_wrap", {56'h0, epoch}, 64'h0);

        // One more refresh, traffic on the new pair, then reset mid-drain.
        refresh_req = 1'b1; tick(); refresh_req = 1'b0;
        wait_idle();
        model_reload();
        for (int i = 0; i < 4; i++) send({$urandom(), $urandom()});
        wait_drain();
        out_ready = 1'b0;
        send(64'hAAAA_5555_AAAA_5555);
        send(64'h5555_AAAA_5555_AAAA);
        refresh_req = 1'b1; tick(); refresh_req = 1'b0;
        @(negedge clk);
        check_val("pre_rst_busy", {63'h0, refresh_busy}, 64'h1);
        check_val("pre_rst_out_valid", {63'h0, out_valid}, 64'h1);
        check_val("pre_rst_epoch", {56'h0, epoch}, 64'd1);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check_val("arst_out_valid", {63'h0, out_valid}, 64'h0);
        check_val("arst_coe_a", {32'h0, coe_a}, {32'h0, SA});
        check_val("arst_coe_b", {32'h0, coe_b}, {32'h0, SB});
        check_val("arst_epoch", {56'h0, epoch}, 64'h0);
        check_val("arst_busy", {63'h0, refresh_busy}, 64'h0);
        check_val("arst_in_ready", {63'h0, in_ready}, 64'h0);
        sb.delete();
        m_a = SA; m_b = SB; m_epoch = 8'd0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_in_ready", {63'h0, in_ready}, 64'h1);
        check_val("post_rst_out_valid", {63'h0, out_valid}, 64'h0);
        out_ready = 1'b1; lat_check = 1'b1;
        tick();
        send_vectors();
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
